alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
Multi-cycle shift-and-add multiplier controller that borrows the shared 8-bit ALU and uses its ADD operation to compute an 8x8 product, truncated to the low 8 bits.
It sits beside the ALU in the processor datapath.
While it owns the ALU, its ALU_* outputs are muxed onto the ALU inputs, selected by ALU_OWN. The top-level mux and the ALU instance are outside this block.
It is started by a one-cycle START from the control unit and reports completion with a one-cycle DONE.

Parameters:
WIDTH, 8, operand, accumulator and product width.
SETTLE_CYCLES, 1, number of cycles ALU inputs are held before ALU_RESULT is sampled (≥1; covers the ALU's combinational delay).

Ports:
CLK  in  1  clock, rising-edge.
RESET  in  1  asynchronous, active-high reset.
START  in  1  start request; sampled only in IDLE.
MCAND  in  WIDTH  multiplicand; latched on the accepting edge.
MPLIER  in  WIDTH  multiplier; latched on the accepting edge.
BUSY  out  1  high whenever state ≠ IDLE.
DONE  out  1  one-cycle completion pulse.
PRODUCT  out  WIDTH  registered result; holds until the next completion.
ALU_OWN  out  1  high only while the sequencer drives the ALU.
ALU_DATA1  out  WIDTH  ALU operand 1 (accumulator).
ALU_DATA2  out  WIDTH  ALU operand 2 (shifted multiplicand).
ALU_SELECT  out  3  ALU opcode.
ALU_RESULT  in  WIDTH  ALU result.

Behaviour:
- Clock/reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state=IDLE; internal registers ACC, M, Q and wait counter = 0; PRODUCT=0, DONE=0, BUSY=0, ALU_OWN=0, ALU_DATA1=0, ALU_DATA2=0, ALU_SELECT=3'b000.
- Reset mid-operation aborts immediately. No DONE pulse is issued and PRODUCT is cleared.
- FSM states: IDLE, STEP, ADD, FIN.
- IDLE: on a clock edge with START=1: M<=MCAND, Q<=MPLIER, ACC<=0; go to STEP.
- STEP, first matching rule applies:
  - Q==0 -> PRODUCT<=ACC, go to FIN.
  - Q[0]==0 -> M<=M<<1, Q<=Q>>1 (zero fill); stay in STEP.
  - Q[0]==1 -> load wait counter with SETTLE_CYCLES; go to ADD.
- ADD:
  - Outputs: ALU_OWN=1, ALU_DATA1=ACC, ALU_DATA2=M, ALU_SELECT=ADD.
  - Counter decrements each cycle.
  - On the SETTLE_CYCLES-th edge in ADD: ACC<=ALU_RESULT, M<=M<<1, Q<=Q>>1; go to STEP.
- FIN: DONE=1 (Moore output); go to IDLE on the next edge.
- ALU drive outside ADD: ALU_OWN=0, ALU_DATA1/ALU_DATA2=0, ALU_SELECT=FWD. All are decoded from registered state only; no glitches from inputs.
- Arithmetic: all sums wrap modulo 2^WIDTH, and M shifts discard the MSB. PRODUCT = (MCAND*MPLIER) mod 2^WIDTH.
- Termination is guaranteed: Q reaches 0 after at most WIDTH shifts.
- Latency: DONE is high in the cycle following (Σ+1) edges after the START-accepting edge.
  - Σ is summed over bit positions 0..msb(MPLIER): 1 per zero bit, 1+SETTLE_CYCLES per one bit.
  - MPLIER=0 gives Σ=0, so DONE appears 1 cycle after acceptance.
- START while BUSY (including the FIN cycle) is ignored; there is no queueing. START in the first IDLE cycle after FIN is accepted.
- MCAND/MPLIER changes after acceptance have no effect.
- PRODUCT changes only on the STEP->FIN edge.

Decomposition:
- Shared package: ALU opcode constants ALU_FWD=3'b000, ALU_ADD=3'b001, ALU_AND=3'b010, ALU_OR=3'b011.
- Same package: FSM state encoding IDLE/STEP/ADD/FIN, plus the default WIDTH.
- Single module, no sub-module: the FSM and the ACC/M/Q/counter registers are tightly coupled.
- The bench instantiates the real ALU and the ALU_OWN mux.

Test Plan:
- RESET pulsed high mid-ADD, asynchronous to CLK -> immediately BUSY=0, DONE=0, ALU_OWN=0, PRODUCT=0x00; no later DONE.
- SETTLE=1, MCAND=0x05, MPLIER=0x03 -> PRODUCT=0x0F; DONE high exactly 5 cycles after acceptance, 1 cycle wide; ALU_OWN high for 2 non-consecutive cycles.
- 0xFF*0xFF -> PRODUCT=0x01, DONE at 17 cycles. 0x10*0x10 -> PRODUCT=0x00 (wrap).
- MPLIER=0x00, MCAND=0xAA -> DONE 1 cycle after acceptance, PRODUCT=0x00, ALU_OWN never high.
- START re-pulsed while BUSY, with MCAND/MPLIER changed mid-run -> ignored; result matches the originally latched operands. START in the cycle after DONE -> accepted, BUSY=1.
- SETTLE=3, 0x07*0x80 -> ALU_OWN high for 3 consecutive cycles with DATA1=0x00, DATA2=0x80, SELECT=001; PRODUCT=0x80; DONE 12 cycles after acceptance.

Source files
------------

// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer: ALU opcodes,
// FSM state encoding and the default datapath width.
package alu_mul_sequencer_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ADD  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 8x8 (truncated) shift-and-add multiplier that borrows the shared
// ALU for its additions; ALU drive is decoded from registered state only.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] MCAND,
  input  logic [WIDTH-1:0] MPLIER,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] PRODUCT,
  output logic             ALU_OWN,
  output logic [WIDTH-1:0] ALU_DATA1,
  output logic [WIDTH-1:0] ALU_DATA2,
  output logic [2:0]       ALU_SELECT,
  input  logic [WIDTH-1:0] ALU_RESULT
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] m, m_nx;
  logic [WIDTH-1:0] q, q_nx;
  logic [WIDTH-1:0] product_q, product_nx;
  logic [CW-1:0]    cnt, cnt_nx;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      acc       <= '0;
      m         <= '0;
      q         <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      m         <= m_nx;
      q         <= q_nx;
      cnt       <= cnt_nx;
      product_q <= product_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    m_nx       = m;
    q_nx       = q;
    cnt_nx     = cnt;
    product_nx = product_q;
    case (state)
      IDLE: begin
        if (START) begin
          m_nx     = MCAND;
          q_nx     = MPLIER;
          acc_nx   = '0;
          state_nx = STEP;
        end
      end
      STEP: begin
        if (q == '0) begin
          product_nx = acc;
          state_nx   = FIN;
        end else if (!q[0]) begin
          m_nx = m << 1;
          q_nx = q >> 1;
        end else begin
          cnt_nx   = CW'(SETTLE_CYCLES);
          state_nx = ADD;
        end
      end
      ADD: begin
        // ALU inputs have been stable for SETTLE_CYCLES once cnt reaches 1
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          acc_nx   = ALU_RESULT;
          m_nx     = m << 1;
          q_nx     = q >> 1;
          state_nx = STEP;
        end
      end
      FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state != IDLE);
    DONE       = (state == FIN);
    ALU_OWN    = (state == ADD);
    ALU_DATA1  = ALU_OWN ? acc : '0;
    ALU_DATA2  = ALU_OWN ? m : '0;
    ALU_SELECT = ALU_OWN ? ALU_ADD : ALU_FWD;
  end

  assign PRODUCT = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (settle 1 and 3), each with its own
// ALU_OWN mux and ALU, driven from a vector table, hand sequences and random runs.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] start;
  logic [7:0] mcand, mplier;
  logic [1:0] busy, done, own;
  logic [7:0] prod[2], d1[2], d2[2], res[2], alu_a[2], alu_b[2];
  logic [2:0] asel[2], alu_op[2];

  int errs = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  alu_mul_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) u_seq1 (
    .CLK(CLK), .RESET(RESET), .START(start[0]), .MCAND(mcand), .MPLIER(mplier),
    .BUSY(busy[0]), .DONE(done[0]), .PRODUCT(prod[0]), .ALU_OWN(own[0]),
    .ALU_DATA1(d1[0]), .ALU_DATA2(d2[0]), .ALU_SELECT(asel[0]), .ALU_RESULT(res[0])
  );

  alu_mul_sequencer #(.WIDTH(8), .SETTLE_CYCLES(3)) u_seq3 (
    .CLK(CLK), .RESET(RESET), .START(start[1]), .MCAND(mcand), .MPLIER(mplier),
    .BUSY(busy[1]), .DONE(done[1]), .PRODUCT(prod[1]), .ALU_OWN(own[1]),
    .ALU_DATA1(d1[1]), .ALU_DATA2(d2[1]), .ALU_SELECT(asel[1]), .ALU_RESULT(res[1])
  );

  // ALU_OWN mux and shared ALU; when not owned, another client drives an OR
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      alu_a[i]  = own[i] ? d1[i] : 8'h3C;
      alu_b[i]  = own[i] ? d2[i] : 8'hC5;
      alu_op[i] = own[i] ? asel[i] : ALU_OR;
      case (alu_op[i])
        ALU_ADD: res[i] = alu_a[i] + alu_b[i];
        ALU_AND: res[i] = alu_a[i] & alu_b[i];
        ALU_OR:  res[i] = alu_a[i] | alu_b[i];
        default: res[i] = alu_a[i];
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: truncated product, edge count to DONE, ALU ownership profile
  function automatic void model(input int st, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] p, output int lat, output int own_c,
                                output int runs, output int fd2);
    logic [15:0] full;
    full = a * b;
    p = full[7:0];
    lat = 1; own_c = 0; runs = 0; fd2 = -1;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) != 0) begin
        if (b[i]) begin
          lat += 1 + st;
          own_c += st;
          runs++;
          if (fd2 < 0) fd2 = (int'(a) << i) & 255;
        end else begin
          lat += 1;
        end
      end
    end
  endfunction

  // Caller is at a negedge. With disturb set, START stays high and operands churn
  // until the DONE cycle has passed.
  task automatic run(input int s, input logic [7:0] a, input logic [7:0] b, input bit disturb,
                     input logic [7:0] exp_p, input int exp_lat, input int exp_own,
                     input int exp_runs, input int exp_fd2, input string tag);
    int j, own_cnt, runs, idle_bad, prod_bad, fd1, fd2;
    bit seen, prev_own;
    logic [7:0] prev_p;
    prev_p = prod[s];
    mcand = a; mplier = b; start[s] = 1'b1;
    @(posedge CLK); #1;
    if (!disturb) start[s] = 1'b0;
    j = 0; own_cnt = 0; runs = 0; idle_bad = 0; prod_bad = 0; fd1 = -1; fd2 = -1;
    seen = 0; prev_own = 0;
    @(negedge CLK);
    chk({tag, " busy_after_accept"}, int'(busy[s]), 1);
    while (!seen && j < 80) begin
      if (own[s]) begin
        own_cnt++;
        if (!prev_own) runs++;
        if (fd2 < 0) begin fd1 = int'(d1[s]); fd2 = int'(d2[s]); end
        if (asel[s] !== ALU_ADD) idle_bad++;
      end else if (d1[s] !== 8'h00 || d2[s] !== 8'h00 || asel[s] !== ALU_FWD) begin
        idle_bad++;
      end
      prev_own = own[s];
      if (done[s]) seen = 1;
      else begin
        if (prod[s] !== prev_p) prod_bad++;
        j++;
        if (disturb) begin mcand = 8'($urandom); mplier = 8'($urandom); end
        @(negedge CLK);
      end
    end
    chk({tag, " done_latency"}, seen ? j : -1, exp_lat);
    chk({tag, " product"}, int'(prod[s]), int'(exp_p));
    chk({tag, " product_held"}, prod_bad, 0);
    chk({tag, " own_cycles"}, own_cnt, exp_own);
    chk({tag, " own_runs"}, runs, exp_runs);
    chk({tag, " alu_drive"}, idle_bad, 0);
    if (exp_own > 0) begin
      chk({tag, " first_data1"}, fd1, 0);
      chk({tag, " first_data2"}, fd2, exp_fd2);
    end
    @(negedge CLK);
    chk({tag, " done_width"}, int'(done[s]), 0);
    chk({tag, " idle_after"}, int'(busy[s]), 0);
    start[s] = 1'b0;
  endtask

  typedef struct {
    int         s;
    logic [7:0] a, b, p;
    int         lat, own_c, runs, fd2;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [7:0] rp;
    int rl, ro, rr, rf, st, guard, late_done;
    logic [7:0] ra, rb;

    vecs[0] = '{0, 8'h05, 8'h03, 8'h0F, 5,  2, 2, 8'h05};
    vecs[1] = '{0, 8'hFF, 8'hFF, 8'h01, 17, 8, 8, 8'hFF};
    vecs[2] = '{0, 8'h10, 8'h10, 8'h00, 7,  1, 1, 8'h00};
    vecs[3] = '{0, 8'hAA, 8'h00, 8'h00, 1,  0, 0, -1};
    vecs[4] = '{1, 8'h07, 8'h80, 8'h80, 12, 3, 1, 8'h80};

    RESET = 1'b1; start = 2'b00; mcand = 8'h00; mplier = 8'h00;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset busy", int'(busy[i]), 0);
      chk("reset done", int'(done[i]), 0);
      chk("reset own", int'(own[i]), 0);
      chk("reset product", int'(prod[i]), 0);
      chk("reset data", int'({d1[i], d2[i]}), 0);
      chk("reset select", int'(asel[i]), int'(ALU_FWD));
    end
    @(negedge CLK);
    RESET = 1'b0;

    foreach (vecs[k])
      run(vecs[k].s, vecs[k].a, vecs[k].b, 1'b0, vecs[k].p, vecs[k].lat,
          vecs[k].own_c, vecs[k].runs, vecs[k].fd2, $sformatf("vec%0d", k));

    // START re-pulsed while busy (through FIN) with churning operands, then
    // a new START in the first idle cycle after DONE
    run(0, 8'h0B, 8'h0D, 1'b1, 8'h8F, 8, 3, 3, 8'h0B, "busy_start");
    run(0, 8'h03, 8'h02, 1'b0, 8'h06, 4, 1, 1, 8'h06, "back_to_back");

    // Asynchronous reset while the sequencer owns the ALU
    mcand = 8'hFF; mplier = 8'hFF; start[0] = 1'b1;
    @(posedge CLK); #1 start[0] = 1'b0;
    guard = 0;
    while (!own[0] && guard < 20) begin @(negedge CLK); guard++; end
    chk("reach ADD", int'(own[0]), 1);
    #2 RESET = 1'b1;
    #1;
    chk("abort busy", int'(busy[0]), 0);
    chk("abort done", int'(done[0]), 0);
    chk("abort own", int'(own[0]), 0);
    chk("abort product", int'(prod[0]), 0);
    chk("abort data2", int'(d2[0]), 0);
    @(negedge CLK);
    RESET = 1'b0;
    late_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      if (done[0] || busy[0]) late_done++;
    end
    chk("no DONE after abort", late_done, 0);

    for (int n = 0; n < 24; n++) begin
      st = int'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      model(st ? 3 : 1, ra, rb, rp, rl, ro, rr, rf);
      run(st, ra, rb, n[0], rp, rl, ro, rr, rf, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
